// File: rtl/running_sum_fifo.sv
// Moving-sum stage: running sum of the last 2^N pre-divided signed samples.
// Optional synchronous flush port enabled by defining RSUM_FLUSH_EN.
module running_sum_fifo #(
  parameter int WIDTH = 24,
  parameter int N     = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] datain,
`ifdef RSUM_FLUSH_EN
  input  logic             flush,
`endif
  output logic             out_valid,
  output logic [WIDTH-1:0] dataout,
  output logic             filled
);

  localparam int           DEPTH    = 1 << N;
  localparam logic [N:0]   FULL_CNT = (N+1)'(DEPTH);
  localparam logic [N:0]   CNT_ONE  = (N+1)'(1);
  localparam logic [N-1:0] PTR_ONE  = N'(1);

  typedef enum logic [0:0] {
    FILL   = 1'b0,
    STEADY = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [N-1:0]     wr_ptr;
  logic [N-1:0]     wr_ptr_next;
  logic [N:0]       count;
  logic [N:0]       count_next;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             out_valid_next;
  logic             write_en;
  logic             flush_req;
  logic [WIDTH-1:0] oldest;
  logic [WIDTH-1:0] ring [DEPTH];

`ifdef RSUM_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  // Slot about to be overwritten is the oldest sample; read before the write lands.
  assign oldest  = ring[wr_ptr];
  assign dataout = acc;
  assign filled  = (state == STEADY);

  // Next-state and datapath update.
  always_comb begin
    state_next     = state;
    wr_ptr_next    = wr_ptr;
    count_next     = count;
    acc_next       = acc;
    out_valid_next = 1'b0;
    write_en       = 1'b0;
    if (flush_req) begin
      state_next  = FILL;
      wr_ptr_next = '0;
      count_next  = '0;
      acc_next    = '0;
    end else if (in_valid) begin
      write_en       = 1'b1;
      out_valid_next = 1'b1;
      wr_ptr_next    = wr_ptr + PTR_ONE;
      case (state)
        FILL: begin
          acc_next   = acc + datain;
          count_next = count + CNT_ONE;
          if (count_next == FULL_CNT) begin
            state_next = STEADY;
          end else begin
            state_next = FILL;
          end
        end
        STEADY: begin
          acc_next = acc + datain - oldest;
        end
        default: begin
          state_next = FILL;
        end
      endcase
    end else begin
      state_next = state;
    end
  end

  // State, pointer, count, accumulator and output-valid registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= FILL;
      wr_ptr    <= '0;
      count     <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      wr_ptr    <= wr_ptr_next;
      count     <= count_next;
      acc       <= acc_next;
      out_valid <= out_valid_next;
    end
  end

  // Ring buffer storage; contents are never read while filling, so no reset.
  always_ff @(posedge clock) begin
    if (write_en && !reset) begin
      ring[wr_ptr] <= datain;
    end
  end

endmodule

// File: doc/running_sum_fifo.md
# running_sum_fifo

Moving-average accumulation stage of the audio noise filter, directly downstream of the divide-by-2^N stage. It takes pre-divided signed 24-bit samples, keeps the last 2^N of them in a circular buffer, and maintains their running sum as sum + newest − oldest. The output is one filtered sample per accepted input, which goes to the codec write path.

## Interface
- WIDTH, 24: sample and accumulator width, signed two's complement.
- N, 3: log2 of window depth; window holds 2^N samples.
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  datain carries a new pre-divided sample this cycle.
- datain  in  WIDTH  signed sample, already divided by 2^N upstream.
- out_valid  out  1  dataout updated this cycle; one-cycle pulse.
- dataout  out  WIDTH  signed running sum of the last 2^N accepted samples.
- filled  out  1  high once 2^N samples have been accepted since reset or flush.
- flush  in  1  synchronous empty request; exists only with RSUM_FLUSH_EN.

## Operation
- Storage: 2^N × WIDTH register ring buffer, write pointer wr_ptr (N bits), occupancy count (N+1 bits), accumulator acc (WIDTH bits).
- Two states:
  - FILL: count < 2^N, filled=0.
  - STEADY: count == 2^N, filled=1.
- Accepted sample (in_valid=1):
  - Write datain to buf[wr_ptr].
  - wr_ptr ← wr_ptr+1 modulo 2^N, wrapping from 2^N−1 to 0.
  - FILL: acc ← acc + datain, count ← count+1. Entering STEADY when count reaches 2^N.
  - STEADY: acc ← acc + datain − buf[wr_ptr], using the value before the overwrite. Count holds.
- Arithmetic is modular in WIDTH bits: no saturation, no overflow flag. Upstream pre-division guarantees in-range sums for legal audio.
- in_valid=0: buf, wr_ptr, count and acc hold. dataout holds its last value.
- dataout = acc register. out_valid=1 exactly in the cycle after each accepted sample.
- Reset values: wr_ptr=0, count=0, acc=0, dataout=0, out_valid=0, filled=0, state FILL. Buffer contents are don't-care, because FILL never reads buf.
- Reset mid-operation: all of the above state is restored on the next edge. A sample presented in the same cycle as reset is dropped.

## Timing
- Latency: 1 cycle from an accepted in_valid edge to the updated dataout and the out_valid pulse.
- Throughput: one sample per cycle with back-to-back in_valid. No backpressure; every in_valid is accepted.
- filled rises in the same cycle as the out_valid for the 2^N-th sample.
- The STEADY subtract reads buf[wr_ptr] combinationally in the same cycle as the write. A read-before-write of the same slot is required.

## Configuration
- RSUM_FLUSH_EN defined:
  - Adds the flush port.
  - flush=1 returns wr_ptr, count, acc and dataout to 0, and filled to 0, on the next edge. out_valid=0 that cycle.
  - flush takes priority over a simultaneous in_valid; that sample is dropped.
  - reset takes priority over flush.
- RSUM_FLUSH_EN undefined: no flush port. State is cleared only by reset.

## Test plan
All scenarios use WIDTH=24, N=3.
- Fill: 8 back-to-back samples of 100 → dataout 100, 200, …, 800 on consecutive cycles. out_valid high for 8 cycles. filled rises with the 800.
- Steady: after fill, sample 100 → 800; then sample 0 → 700; then 7 more 0s → 0. Wrap of wr_ptr exercised.
- Negative/gapped: alternate in_valid on and off with datain=24'hFFFFFF (−1) ×8 → dataout −1…−8. out_valid low and dataout held on idle cycles.
- Modular wrap: two samples of 24'h7FFFFF → dataout 24'h7FFFFF, then 24'hFFFFFE.
- Reset mid-fill: 5 samples of 10 (dataout 50), reset 1 cycle → dataout 0, filled 0; next sample 50 → 50.
- Flush (RSUM_FLUSH_EN): 8 samples of 10, then flush together with in_valid=1 and datain=99 → dataout 0, filled 0, sample dropped; next sample 7 → 7.
